// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the divider-sharing controller.
//   div_state_e  - controller FSM state encoding (IDLE must stay 0 so a reset
//                  controller reads back as all-zero on its debug output).
//   DIV_*_W      - operand/result widths of the shared iterative divider.
//   DIV_ERR_QUOT - quotient returned for a divide-by-zero request.
package div_pkg;

  localparam int DIV_DIVIDEND_W = 10;
  localparam int DIV_DIVISOR_W  = 3;
  localparam int DIV_QUOT_W     = 20;

  localparam logic [DIV_QUOT_W-1:0] DIV_ERR_QUOT = 20'hFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_HOLD   = 2'd2,
    ST_RESP   = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_rr_pick.sv
// div_rr_pick: combinational round-robin picker.
//   req        in   NUM_REQ  active requests
//   last_grant in   ID_W     index granted most recently; search starts one above it
//   grant_oh   out  NUM_REQ  one-hot winner (all zero when no request)
//   grant_idx  out  ID_W     index of the winner (0 when no request)
//   any_req    out  1        at least one request is active
// The pointer register itself lives in the caller.
module div_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_req
);

  logic            found;
  int              pos;
  logic [ID_W-1:0] pos_w;

  assign any_req = |req;

  // Walk the requesters in priority order last_grant+1, last_grant+2, ...
  // wrapping modulo NUM_REQ; the first active one wins.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = 0;
    pos_w     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos   = (int'(last_grant) + k) % NUM_REQ;
      pos_w = ID_W'(pos);
      if (!found && req[pos_w]) begin
        found           = 1'b1;
        grant_oh[pos_w] = 1'b1;
        grant_idx       = pos_w;
      end
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// div_share_ctrl: shares one iterative divider among NUM_REQ requesters.
//   clk, rst_n                  clock, synchronous active-low reset
//   req_valid/req_ready         per-requester request handshake (ready is a one-hot pulse)
//   req_dividend/req_divisor    flattened operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready         response handshake
//   rsp_id/rsp_quotient/rsp_err response payload (err = divide-by-zero)
//   div_in_valid/div_in_data_*  divider launch strobe and operands
//   div_out_valid/div_out_data  divider result (valid may last 1-2 cycles)
//   dbg_state                   current FSM state
//
// Handshake semantics: a transfer happens on a rising clk edge where valid and
// ready are both high. A source keeps valid and its payload stable until that
// edge; ready may depend combinationally on valid (req_ready does).
module div_share_ctrl
  import div_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ*DIV_DIVIDEND_W-1:0]   req_dividend,
  input  logic [NUM_REQ*DIV_DIVISOR_W-1:0]    req_divisor,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [ID_W-1:0]                     rsp_id,
  output logic [DIV_QUOT_W-1:0]               rsp_quotient,
  output logic                                rsp_err,
  output logic                                div_in_valid,
  output logic [DIV_DIVIDEND_W-1:0]           div_in_data_1,
  output logic [DIV_DIVISOR_W-1:0]            div_in_data_2,
  input  logic                                div_out_valid,
  input  logic [DIV_QUOT_W-1:0]               div_out_data,
  output logic [1:0]                          dbg_state
);

  div_state_e                 state_q, state_d;
  logic [ID_W-1:0]            last_grant_q, last_grant_d;
  logic [ID_W-1:0]            op_id_q, op_id_d;
  logic [DIV_DIVIDEND_W-1:0]  op_dividend_q, op_dividend_d;
  logic [DIV_DIVISOR_W-1:0]   op_divisor_q, op_divisor_d;
  logic [DIV_QUOT_W-1:0]      quot_q, quot_d;
  logic                       err_q, err_d;

  logic [NUM_REQ-1:0]         pick_oh;
  logic [ID_W-1:0]            pick_idx;
  logic                       any_req;
  logic [DIV_DIVIDEND_W-1:0]  sel_dividend;
  logic [DIV_DIVISOR_W-1:0]   sel_divisor;
  logic                       grant_ok;
  logic                       op_active;

  div_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant_oh   (pick_oh),
    .grant_idx  (pick_idx),
    .any_req    (any_req)
  );

  assign sel_dividend = req_dividend[int'(pick_idx)*DIV_DIVIDEND_W +: DIV_DIVIDEND_W];
  assign sel_divisor  = req_divisor[int'(pick_idx)*DIV_DIVISOR_W +: DIV_DIVISOR_W];

  // A grant waits for div_out_valid to drop, so the tail of a two-cycle
  // result pulse can never be mistaken for the next request's result.
  // rst_n keeps req_ready quiet while reset is held, since nothing would be latched.
  assign grant_ok = rst_n && (state_q == ST_IDLE) && any_req && !div_out_valid;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= ID_W'(NUM_REQ - 1);
      op_id_q       <= '0;
      op_dividend_q <= '0;
      op_divisor_q  <= '0;
      quot_q        <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      op_id_q       <= op_id_d;
      op_dividend_q <= op_dividend_d;
      op_divisor_q  <= op_divisor_d;
      quot_q        <= quot_d;
      err_q         <= err_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_ok) begin
          state_d = (sel_divisor == '0) ? ST_RESP : ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_d = ST_HOLD;
      ST_HOLD: begin
        if (div_out_valid) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: operands latched at grant, result captured on the
  // first div_out_valid cycle seen in HOLD (later cycles land in RESP and are ignored).
  always_comb begin
    last_grant_d  = last_grant_q;
    op_id_d       = op_id_q;
    op_dividend_d = op_dividend_q;
    op_divisor_d  = op_divisor_q;
    quot_d        = quot_q;
    err_d         = err_q;
    if (grant_ok) begin
      last_grant_d  = pick_idx;
      op_id_d       = pick_idx;
      op_dividend_d = sel_dividend;
      op_divisor_d  = sel_divisor;
      if (sel_divisor == '0) begin
        quot_d = DIV_ERR_QUOT;
        err_d  = 1'b1;
      end
    end
    if ((state_q == ST_HOLD) && div_out_valid) begin
      quot_d = div_out_data;
      err_d  = 1'b0;
    end
  end

  // Outputs.
  always_comb begin
    op_active     = (state_q == ST_LAUNCH) || (state_q == ST_HOLD);
    req_ready     = grant_ok ? pick_oh : '0;
    rsp_valid     = (state_q == ST_RESP);
    div_in_valid  = (state_q == ST_LAUNCH);
    div_in_data_1 = op_active ? op_dividend_q : '0;
    div_in_data_2 = op_active ? op_divisor_q : '0;
  end

  assign rsp_id       = op_id_q;
  assign rsp_quotient = quot_q;
  assign rsp_err      = err_q;
  assign dbg_state    = state_q;

endmodule

// File: doc/div_share_ctrl.md
# div_share_ctrl

Round-robin controller that shares one iterative divider (10-bit dividend, 3-bit divisor, 20-bit quotient, in_valid/out_valid protocol) among NUM_REQ requesters. Each request is accepted with a valid/ready handshake. The controller launches the divider, holds its operands stable for the whole computation, captures the quotient and returns it with the requester ID. Divide-by-zero requests are answered directly and never reach the divider.

## Interface
- NUM_REQ, 4: number of requesters, minimum 2.
- ID_W, $clog2(NUM_REQ): width of rsp_id.
- clk  in  1  clock.
- rst_n  in  1  reset. Synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request. Held, with its data stable, until accepted.
- req_dividend  in  NUM_REQ*10  flattened dividends. Requester i uses bits [i*10 +: 10].
- req_divisor  in  NUM_REQ*3  flattened divisors. Requester i uses bits [i*3 +: 3].
- req_ready  out  NUM_REQ  one-hot accept pulse, combinational in IDLE.
- rsp_valid  out  1  response valid. Held until rsp_ready.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  index of the requester being answered.
- rsp_quotient  out  20  quotient; 20'hFFFFF on error.
- rsp_err  out  1  divide-by-zero.
- div_in_valid  out  1  divider start strobe.
- div_in_data_1  out  10  divider dividend.
- div_in_data_2  out  3  divider divisor.
- div_out_valid  in  1  divider result valid. Lasts 1–2 cycles.
- div_out_data  in  20  divider result.

## Operation
- States: IDLE, LAUNCH, HOLD, RESP.
- **IDLE**
  - A grant requires any req_valid and div_out_valid==0.
  - Winner is chosen round-robin, starting from (last_grant+1) mod NUM_REQ.
  - On grant: req_ready[winner]=1 that cycle; dividend, divisor and ID are latched into op registers; last_grant←winner.
  - If the latched divisor is nonzero, go to LAUNCH.
  - If the latched divisor is 0, set rsp_err=1, rsp_quotient=20'hFFFFF and go to RESP. The divider is not touched.
- **LAUNCH**: div_in_valid=1 for exactly one cycle, then go to HOLD.
- **HOLD**
  - div_in_data_1 and div_in_data_2 stay driven from the op registers from LAUNCH until HOLD exits.
  - On the first cycle with div_out_valid=1: capture div_out_data into rsp_quotient, set rsp_err=0, go to RESP.
- **RESP**
  - rsp_valid=1. When rsp_valid && rsp_ready, go to IDLE.
  - rsp_id, rsp_quotient and rsp_err are stable while rsp_valid=1.
- **Arithmetic**: the quotient is opaque. The controller passes it through unmodified; a zero dividend is a legal launch.
- **Reset**: all outputs 0. State←IDLE, last_grant←NUM_REQ-1 so requester 0 has first priority, op registers←0.
- **Boundaries**
  - Several requests in the same cycle: exactly one req_ready bit is set; the others wait.
  - A requester that drops req_valid before grant is never granted; no partial accept.
  - Requests arriving outside IDLE are ignored until IDLE.
  - The IDLE gate on div_out_valid==0 guarantees the second div_out_valid cycle is never seen as a new result.
  - rsp_ready held high: rsp_valid is a one-cycle pulse.
  - Reset mid-operation: an in-flight request is discarded with no response. The divider shares rst_n.
  - div_out_valid outside HOLD is ignored.

## Timing
- Grant at cycle T. LAUNCH occupies T+1. HOLD begins T+2.
- Response latency is divider latency + 2 cycles, measured from the grant to the first rsp_valid cycle.
- A divide-by-zero response has rsp_valid at T+1.
- Back-to-back: the next grant comes no earlier than one cycle after the rsp handshake, and only once div_out_valid==0.
- Fairness: under full load, each requester is granted at least once every NUM_REQ grants.

## Structure
- **Package div_pkg**
  - State enum.
  - Constants DIV_DIVIDEND_W=10, DIV_DIVISOR_W=3, DIV_QUOT_W=20, DIV_ERR_QUOT=20'hFFFFF.
- **Sub-module div_rr_pick**
  - Inputs: req vector and last_grant pointer.
  - Outputs: one-hot grant, grant index, any_req.
  - Purely combinational.
  - The pointer register stays in div_share_ctrl.

## Test plan
- **Single request**: req 1 with dividend 10'd100, divisor 3'd4. Stub divider returns 20'h0ABCD after 20 cycles. Expect div_in_valid at T+1 only, operands stable through HOLD, and rsp_id=1, rsp_quotient=20'h0ABCD, rsp_err=0 at T+22.
- **Divide-by-zero**: req 2 with divisor 0. Expect rsp_valid at T+1 with rsp_err=1, rsp_quotient=20'hFFFFF, and div_in_valid never asserted.
- **Fairness**: all 4 req_valid held high across 8 transactions with rsp_ready=1. Grant order must be 0,1,2,3,0,1,2,3.
- **Backpressure**: rsp_ready low for 10 cycles. rsp_valid and rsp data stay held, no new grant occurs, and the single response is accepted on the first rsp_ready.
- **Two-cycle out_valid**: stub holds div_out_valid for 2 cycles with different data each cycle. The first value must be captured, and the next grant may occur only after div_out_valid drops.
- **Reset**: assert rst_n=0 during HOLD. All outputs are 0 next cycle; after release, req 0 wins against req 3 when both request together.
